// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter.
//   NREQ_DEFAULT : default number of requesters sharing the multiplier
//   W_DEFAULT    : default operand width (product width is 2*W)
//   state_t      : arbiter FSM state encoding
package mult_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned W_DEFAULT    = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StMul  = 1'b1
    } state_t;

endpackage

// File: rtl/multiplier8.sv
// Combinational unsigned multiplier.
//   a : input  W    operand A
//   b : input  W    operand B
//   p : output 2*W  full-width unsigned product a*b
module multiplier8 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Widen both operands so the product is computed at full width.
    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier8 among NREQ requesters.
// Each transaction takes two cycles: IDLE captures the winner's operands and
// pulses gnt, MUL registers the product and pulses done.
//   clk   : input  1       rising-edge clock
//   rst_n : input  1       asynchronous active-low reset
//   req   : input  NREQ    level requests
//   a_in  : input  NREQ*W  packed operand A, requester i at [i*W +: W]
//   b_in  : input  NREQ*W  packed operand B, same packing
//   gnt   : output NREQ    one-hot operand-capture pulse
//   done  : output NREQ    one-hot product-valid pulse
//   p_out : output 2*W     registered product, held between transactions
//   busy  : output 1       high while not in IDLE
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned W    = W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [2*W-1:0]      p_out,
    output logic                busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0] NREQ_W = (IW + 1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ - 1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_idx_q, win_idx_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [2*W-1:0]  p_q, p_d;
    logic [2*W-1:0]  prod;

    logic [IW-1:0]   win;
    logic            found;
    logic [IW:0]     pos;

    multiplier8 #(
        .W (W)
    ) u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

    // First set request at or above ptr, wrapping modulo NREQ. pos is one bit
    // wider than ptr so ptr+off never overflows before the modulo fold.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        pos   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            pos = {1'b0, ptr_q} + (IW + 1)'(off);
            if (pos >= NREQ_W) begin
                pos = pos - NREQ_W;
            end
            if (!found && req[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        gnt_d     = '0;
        done_d    = '0;
        p_d       = p_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    op_a_d    = a_in[win*W +: W];
                    op_b_d    = b_in[win*W +: W];
                    gnt_d     = ONE_HOT0 << win;
                    win_idx_d = win;
                    state_d   = StMul;
                end
            end
            StMul: begin
                // req and operand inputs are deliberately ignored here.
                p_d     = prod;
                done_d  = ONE_HOT0 << win_idx_q;
                ptr_d   = (win_idx_q == IW'(NREQ - 1)) ? '0 : win_idx_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            win_idx_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            p_q       <= p_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign p_out = p_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_mult_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] p_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mult_arbiter #(
        .NREQ (4),
        .W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a_in  (a_in),
        .b_in  (b_in),
        .gnt   (gnt),
        .done  (done),
        .p_out (p_out),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*8 +: 8] = a;
        b_in[i*8 +: 8] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " gnt"},   32'(gnt),   32'd0);
        check({tag, " done"},  32'(done),  32'd0);
        check({tag, " p_out"}, 32'(p_out), 32'd0);
        check({tag, " busy"},  32'(busy),  32'd0);
    endtask

    // Called on a falling edge: raise reqv, expect gnt next cycle, drop all
    // requests, then expect done with the same one-hot and the product.
    task automatic txn(input string tag, input logic [3:0] reqv, input logic [3:0] expg,
                       input logic [15:0] expp);
        req = reqv;
        @(negedge clk);
        check({tag, " gnt"},       32'(gnt),  32'(expg));
        check({tag, " gnt_done"},  32'(done), 32'd0);
        check({tag, " busy_mul"},  32'(busy), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        check({tag, " done"},      32'(done),  32'(expg));
        check({tag, " p_out"},     32'(p_out), 32'(expp));
        check({tag, " gnt_clear"}, 32'(gnt),   32'd0);
        check({tag, " busy_idle"}, 32'(busy),  32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0]  exp_g;
    logic [15:0] all4_p [4] = '{16'd221, 16'd600, 16'd7623, 16'd255};

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        a_in  = '0;
        b_in  = '0;
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle_no_req");

        // Single request and corner operands.
        set_op(0, 8'd66, 8'd61);
        txn("single0", 4'b0001, 4'b0001, 16'd4026);
        @(negedge clk);
        check("hold p_out", 32'(p_out), 32'd4026);
        check("hold done",  32'(done),  32'd0);
        set_op(1, 8'd120, 8'd240);
        txn("corner1", 4'b0010, 4'b0010, 16'd28800);
        set_op(2, 8'd255, 8'd255);
        txn("corner2", 4'b0100, 4'b0100, 16'd65025);
        set_op(3, 8'd8, 8'd8);
        txn("corner3", 4'b1000, 4'b1000, 16'd64);
        set_op(0, 8'd0, 8'd200);
        txn("corner0", 4'b0001, 4'b0001, 16'd0);

        // All four requesting from reset; each drops its req on gnt.
        do_reset();
        set_op(0, 8'd13, 8'd17);
        set_op(1, 8'd200, 8'd3);
        set_op(2, 8'd77, 8'd99);
        set_op(3, 8'd255, 8'd1);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_g = 4'b0001 << i;
            @(negedge clk);
            check($sformatf("all4 gnt%0d", i), 32'(gnt), 32'(exp_g));
            req[i] = 1'b0;
            @(negedge clk);
            check($sformatf("all4 done%0d", i), 32'(done), 32'(exp_g));
            check($sformatf("all4 p%0d", i), 32'(p_out), 32'(all4_p[i]));
        end

        // Fairness: requesters 0 and 2 keep requesting.
        do_reset();
        set_op(0, 8'd5, 8'd6);
        set_op(2, 8'd9, 8'd11);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = (k % 2 == 0) ? 0 : 2;
            exp_g = 4'b0001 << w;
            @(negedge clk);
            check($sformatf("fair gnt%0d", k), 32'(gnt), 32'(exp_g));
            req[w] = 1'b0;
            @(negedge clk);
            check($sformatf("fair done%0d", k), 32'(done), 32'(exp_g));
            check($sformatf("fair p%0d", k), 32'(p_out), (w == 0) ? 32'd30 : 32'd99);
            req[w] = 1'b1;
        end
        req = 4'b0000;
        @(negedge clk);

        // Operand change while in MUL must not affect the product.
        set_op(0, 8'd20, 8'd30);
        req = 4'b0001;
        @(negedge clk);
        check("opchg gnt", 32'(gnt), 32'd1);
        req = 4'b0000;
        set_op(0, 8'd255, 8'd255);
        @(negedge clk);
        check("opchg done",  32'(done),  32'd1);
        check("opchg p_out", 32'(p_out), 32'd600);

        // Reset while in MUL: outputs clear at once, no late done.
        set_op(1, 8'd12, 8'd12);
        req = 4'b0010;
        @(negedge clk);
        check("midrst gnt", 32'(gnt), 32'd2);
        check("midrst busy_pre", 32'(busy), 32'd1);
        req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midrst no_done%0d", c), 32'(done), 32'd0);
            check($sformatf("midrst no_busy%0d", c), 32'(busy), 32'd0);
        end
        // Search restarts at bit 0: with 1 and 3 requesting, 1 wins.
        set_op(1, 8'd6, 8'd7);
        set_op(3, 8'd9, 8'd9);
        txn("post_rst_rr", 4'b1010, 4'b0010, 16'd42);
        set_op(2, 8'd7, 8'd9);
        txn("post_rst_req2", 4'b0100, 4'b0100, 16'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one multiplier8 (fixed at 4 for this revision).
REQ-002 The block SHALL have parameter W, default 8, meaning the operand width; the product width is 2*W.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Clock port: clk. Reset port: rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NREQ  level request per requester; bit i high means operands on a_in/b_in slice i are valid.
REQ-007 a_in  input  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
REQ-008 b_in  input  NREQ*W  packed operand B, same packing as a_in.
REQ-009 gnt  output  NREQ  one-hot, registered, one-cycle pulse marking operand capture for the winner.
REQ-010 done  output  NREQ  one-hot, registered, one-cycle pulse marking p_out valid for the winner.
REQ-011 p_out  output  2*W  registered product; valid only while done is nonzero; holds its value otherwise.
REQ-012 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have two states: IDLE and MUL.
REQ-014 In IDLE with req==0: stay in IDLE; gnt, done and busy SHALL be 0.
REQ-015 In IDLE with req!=0: the winner is the first set req bit searching upward from ptr, modulo NREQ. On the same edge, op_a/op_b SHALL latch the winner's slices, gnt[winner] SHALL be set, win_idx SHALL be stored, and the FSM SHALL move to MUL.
REQ-016 In MUL: on the next edge, p_out SHALL load multiplier8(op_a,op_b), done[win_idx] SHALL be set, gnt SHALL clear, ptr SHALL become (win_idx+1) mod NREQ, and the FSM SHALL return to IDLE.
REQ-017 Latency: the product SHALL appear 2 edges after req is first sampled high in IDLE. Throughput SHALL be one product per 2 cycles.
REQ-018 gnt and done SHALL each be high for exactly one cycle per transaction and SHALL never be high in the same cycle.
REQ-019 The requester holds a/b stable until it sees gnt. It SHALL drop req on the edge at which gnt is high. req still high at the next IDLE SHALL count as a new request.
REQ-020 Changes on req or a_in/b_in while in MUL SHALL be ignored.
REQ-021 Wrap-around: with ptr=NREQ-1 and req[NREQ-1]=0, the search SHALL continue from bit 0.
REQ-022 A lone requester SHALL be served every 2 cycles with no starvation. Any requester holding req SHALL be served within NREQ transactions.
REQ-023 Arithmetic is unsigned. 2*W bits SHALL hold any product without overflow; no truncation.

Reset
REQ-024 On rst_n low, immediately and regardless of state: state=IDLE, ptr=0, win_idx=0, op_a=0, op_b=0, gnt=0, done=0, p_out=0, busy=0.
REQ-025 A transaction interrupted by reset SHALL be dropped; no done SHALL be issued for it after reset releases.
REQ-026 The first arbitration after reset release SHALL start searching at bit 0.

Structure
REQ-027 The state encoding (IDLE, MUL), W and NREQ defaults SHALL live in the shared package mult_pkg.
REQ-028 The product SHALL come from a single instance of the existing combinational multiplier8 (ports a, b, p). No second multiplier is permitted.
REQ-029 The round-robin winner search SHALL be combinational logic inside mult_arbiter; no further sub-modules.

Verification
REQ-030 Single request: req=0001, a0=66, b0=61 -> gnt=0001 one cycle later, then done=0001 with p_out=4026.
REQ-031 Corner values: a1=120,b1=240 -> p_out=28800. a2=255,b2=255 -> p_out=65025. a3=8,b3=8 -> p_out=64. a0=0,b0=200 -> p_out=0.
REQ-032 All four requesting from reset, each dropping req on its gnt -> done order 0,1,2,3 on edges 2,4,6,8; each product correct for its operands.
REQ-033 Fairness: req0 and req2 held continuously, re-asserted after each gnt -> service alternates 0,2,0,2; neither is served twice in a row.
REQ-034 Reset mid-operation: assert rst_n=0 while in MUL -> all outputs 0 asynchronously; no done after release; a new req=0100 afterwards is served with correct p_out.
REQ-035 Operand change during MUL: modify a0/b0 after gnt -> p_out reflects the values captured at gnt.
